or90_dac: RTL and testbench

Two-channel first-order delta-sigma DAC for the Orchestra 90 emulation path. It sits directly downstream of the Orchestra 90 channel-write decode and latches the 8-bit unsigned samples written to the left and right channel ports. It replaces the external DAC latches with two 1-bit density outputs driving RC filters. The outputs start up with an anti-pop ramp, and left/right updates are frame-synchronised so a stereo pair written in consecutive bus cycles changes together.

---
 rtl/or90_dac_if.sv | 21 ++
 rtl/or90_dac.sv | 106 ++++++++++
 tb/tb_or90_dac.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/or90_dac_if.sv
// Orchestra 90 DAC bus bundle: channel-write side in, density bits and status out.
interface or90_dac_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic [1:0]       wr;
    logic             dac_l;
    logic             dac_r;
    logic             pend;
    logic             ramping;

    modport master (
        output data, wr,
        input  dac_l, dac_r, pend, ramping
    );

    modport slave (
        input  data, wr,
        output dac_l, dac_r, pend, ramping
    );
endinterface

// File: rtl/or90_dac.sv
// Two-channel first-order delta-sigma DAC with anti-pop soft start and
// frame-synchronised stereo updates for the Orchestra 90 emulation path.
module or90_dac #(
    parameter int WIDTH      = 8,
    parameter int RAMP_DIV   = 4,
    parameter int FRAME_BITS = 8
) (
    input  logic        e,
    input  logic        _reset,
    or90_dac_if.slave   bus
);
    localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DW-1:0]    DLAST = DW'(RAMP_DIV - 1);
    localparam logic [WIDTH-1:0] MID   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {RAMP = 1'b0, RUN = 1'b1} state_t;

    state_t                state_q;
    logic                  ramping_q;
    logic [WIDTH-1:0]      r_q;
    logic [DW-1:0]         d_q;
    logic [FRAME_BITS-1:0] fctr_q;
    logic                  load;
    logic                  div_wrap;
    logic [1:0]            pnd_v;
    logic [1:0]            dac_v;

    // Load edge: last clock of the frame, both channels swap staged->active together.
    assign load     = &fctr_q;
    assign div_wrap = (d_q == DLAST);

    // Free-running frame counter.
    always_ff @(posedge e or negedge _reset) begin
        if (!_reset) fctr_q <= '0;
        else         fctr_q <= fctr_q + 1'b1;
    end

    // Soft-start FSM: ramp level 0 -> midscale, then hold one extra divider period.
    always_ff @(posedge e or negedge _reset) begin
        if (!_reset) begin
            state_q   <= RAMP;
            ramping_q <= 1'b1;
            r_q       <= '0;
            d_q       <= '0;
        end else begin
            case (state_q)
                RAMP: begin
                    d_q <= div_wrap ? '0 : d_q + 1'b1;
                    if (div_wrap && (r_q < MID)) r_q <= r_q + 1'b1;
                    if (div_wrap && (r_q == MID)) begin
                        state_q   <= RUN;
                        ramping_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    ramping_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [WIDTH-1:0] stg_q, stg_d;
        logic [WIDTH-1:0] act_q, act_d;
        logic [WIDTH-1:0] acc_q;
        logic [WIDTH-1:0] lvl;
        logic [WIDTH:0]   sum;
        logic             pnd_q, pnd_d;
        logic             dac_q;

        // Staging/active/pending next state and the modulator sum.
        always_comb begin
            stg_d = bus.wr[ch] ? bus.data : stg_q;
            act_d = load ? stg_q : act_q;
            pnd_d = bus.wr[ch] | (pnd_q & ~load);
            lvl   = (state_q == RUN) ? act_q : r_q;
            sum   = {1'b0, acc_q} + {1'b0, lvl};
        end

        // Per-channel sample registers and first-order modulator.
        always_ff @(posedge e or negedge _reset) begin
            if (!_reset) begin
                stg_q <= MID;
                act_q <= MID;
                pnd_q <= 1'b0;
                acc_q <= '0;
                dac_q <= 1'b0;
            end else begin
                stg_q <= stg_d;
                act_q <= act_d;
                pnd_q <= pnd_d;
                acc_q <= sum[WIDTH-1:0];
                dac_q <= sum[WIDTH];
            end
        end

        assign pnd_v[ch] = pnd_q;
        assign dac_v[ch] = dac_q;
    end

    assign bus.dac_l   = dac_v[0];
    assign bus.dac_r   = dac_v[1];
    assign bus.pend    = |pnd_v;
    assign bus.ramping = ramping_q;
endmodule

// File: tb/tb_or90_dac.sv
// Directed bench for or90_dac: ramp timing/density, frame-synchronised loads,
// write-on-load-edge, RAMP-time writes and asynchronous reset.
module tb_or90_dac;
    logic e;
    logic _reset;
    int   n;
    int   errors;
    int   checks;

    or90_dac_if #(.WIDTH(8)) bus ();

    or90_dac #(.WIDTH(8), .RAMP_DIV(4), .FRAME_BITS(8)) dut (
        .e      (e),
        ._reset (_reset),
        .bus    (bus)
    );

    initial begin
        e = 1'b0;
        forever #5 e = ~e;
    end

    typedef struct {
        string      name;
        int         wait_f;
        logic [1:0] wr;
        logic [7:0] data;
        int         run;
        int         exp_l;
        int         exp_r;
        int         tol;
        logic       exp_pend;
    } vec_t;

    vec_t vt[16];

    function automatic vec_t mk(string nm, int wf, logic [1:0] w, logic [7:0] d,
                                int r, int el, int er, int t, logic ep);
        vec_t v;
        v.name = nm; v.wait_f = wf; v.wr = w; v.data = d; v.run = r;
        v.exp_l = el; v.exp_r = er; v.tol = t; v.exp_pend = ep;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp, int tol);
        int diff;
        checks++;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at edge %0d", nm, act, exp, tol, n);
        end
    endtask

    task automatic step();
        @(posedge e);
        #1;
        n++;
    endtask

    task automatic run_cnt(int k, output int cl, output int cr);
        cl = 0;
        cr = 0;
        for (int i = 0; i < k; i++) begin
            step();
            cl += int'(bus.dac_l);
            cr += int'(bus.dac_r);
        end
    endtask

    // Full soft-start window; optional both-channel write of 0x00 when r = 0x30.
    task automatic ramp_phase(bit do_wr);
        int cl, cr;
        cl = 0;
        cr = 0;
        for (int m = 1; m <= 516; m++) begin
            if (do_wr && m == 193) begin
                bus.wr   = 2'b11;
                bus.data = 8'h00;
            end
            step();
            bus.wr = 2'b00;
            cl += int'(bus.dac_l);
            cr += int'(bus.dac_r);
            if (m == 515) chk("ramping_at_515", int'(bus.ramping), 1, 0);
            if (m == 516) chk("ramping_at_516", int'(bus.ramping), 0, 0);
            if (do_wr && m == 193) chk("ramp_wr_pend_set", int'(bus.pend), 1, 0);
            if (do_wr && m == 256) chk("ramp_wr_pend_clr", int'(bus.pend), 0, 0);
        end
        // Sum of ramp levels over 516 edges is 129*256, so exactly 129 ones.
        chk("ramp_ones_l", cl, 129, 0);
        chk("ramp_ones_r", cr, 129, 0);
    endtask

    initial begin
        int cl, cr, tl, tr;
        errors = 0;
        checks = 0;
        n      = 0;

        vt[0]  = mk("wr_l_ff_pend",      16, 2'b01, 8'hFF,   1,  -1,  -1, 0, 1'b1);
        vt[1]  = mk("pend_held_to_load", -1, 2'b00, 8'h00, 238,  -1,  -1, 0, 1'b1);
        vt[2]  = mk("load_clears_pend",  -1, 2'b00, 8'h00,   1,  -1,  -1, 0, 1'b0);
        vt[3]  = mk("density_ff_vs_80",  -1, 2'b00, 8'h00, 256, 255, 128, 0, 1'b0);
        vt[4]  = mk("wr_l_00_at_fe",    254, 2'b01, 8'h00,   1,  -1,  -1, 0, 1'b1);
        vt[5]  = mk("load_l_00",         -1, 2'b00, 8'h00,   1,  -1,  -1, 0, 1'b0);
        vt[6]  = mk("wr_r_40_at_02",      2, 2'b10, 8'h40,   1,  -1,  -1, 0, 1'b1);
        vt[7]  = mk("pend_before_load",  255, 2'b00, 8'h00,  0,  -1,  -1, 0, 1'b1);
        vt[8]  = mk("load_r_40",         -1, 2'b00, 8'h00,   1,  -1,  -1, 0, 1'b0);
        vt[9]  = mk("density_00_vs_40",  -1, 2'b00, 8'h00, 256,   0,  64, 0, 1'b0);
        vt[10] = mk("wr_r_20_on_load",  255, 2'b10, 8'h20,   1,  -1,  -1, 0, 1'b1);
        vt[11] = mk("act_r_kept_40",     -1, 2'b00, 8'h00, 255,   0,  64, 1, 1'b1);
        vt[12] = mk("load_r_20",         -1, 2'b00, 8'h00,   1,  -1,  -1, 0, 1'b0);
        vt[13] = mk("density_00_vs_20",  -1, 2'b00, 8'h00, 256,   0,  32, 0, 1'b0);
        vt[14] = mk("wr_both_00_load",  255, 2'b11, 8'h00,   1,  -1,  -1, 0, 1'b1);
        vt[15] = mk("load_both_00",      -1, 2'b00, 8'h00, 256,   0,  -1, 0, 1'b0);

        // Reset state.
        _reset   = 1'b0;
        bus.wr   = 2'b00;
        bus.data = 8'h00;
        #12;
        chk("rst_dac_l",   int'(bus.dac_l),   0, 0);
        chk("rst_dac_r",   int'(bus.dac_r),   0, 0);
        chk("rst_pend",    int'(bus.pend),    0, 0);
        chk("rst_ramping", int'(bus.ramping), 1, 0);
        #1 _reset = 1'b1;

        ramp_phase(1'b0);

        // Midscale after the ramp: accumulator is 0, so 0 then 1.
        step();
        chk("run_alt0_l", int'(bus.dac_l), 0, 0);
        chk("run_alt0_r", int'(bus.dac_r), 0, 0);
        step();
        chk("run_alt1_l", int'(bus.dac_l), 1, 0);
        chk("run_alt1_r", int'(bus.dac_r), 1, 0);
        run_cnt(256, cl, cr);
        chk("run_mid_ones_l", cl, 128, 0);
        chk("run_mid_ones_r", cr, 128, 0);

        // Frame-synchronised write vectors.
        foreach (vt[i]) begin
            if (vt[i].wait_f >= 0)
                while ((n % 256) != vt[i].wait_f) step();
            tl = 0;
            tr = 0;
            if (vt[i].run > 0) begin
                bus.wr   = vt[i].wr;
                bus.data = vt[i].data;
                run_cnt(1, cl, cr);
                bus.wr = 2'b00;
                tl += cl;
                tr += cr;
                run_cnt(vt[i].run - 1, cl, cr);
                tl += cl;
                tr += cr;
            end
            chk({vt[i].name, "_pend"}, int'(bus.pend), int'(vt[i].exp_pend), 0);
            if (vt[i].exp_l >= 0) chk({vt[i].name, "_l"}, tl, vt[i].exp_l, vt[i].tol);
            if (vt[i].exp_r >= 0) chk({vt[i].name, "_r"}, tr, vt[i].exp_r, vt[i].tol);
        end

        // Asynchronous reset mid-frame in RUN with a sample pending.
        bus.wr   = 2'b01;
        bus.data = 8'hFF;
        step();
        bus.wr = 2'b00;
        chk("pre_rst_pend",    int'(bus.pend),    1, 0);
        chk("pre_rst_ramping", int'(bus.ramping), 0, 0);
        run_cnt(5, cl, cr);
        #2 _reset = 1'b0;
        #1;
        chk("async_rst_dac_l",   int'(bus.dac_l),   0, 0);
        chk("async_rst_dac_r",   int'(bus.dac_r),   0, 0);
        chk("async_rst_pend",    int'(bus.pend),    0, 0);
        chk("async_rst_ramping", int'(bus.ramping), 1, 0);
        @(posedge e);
        @(posedge e);
        #3 _reset = 1'b1;
        n = 0;

        // Ramp restarts from 0; write of 0x00 to both at r = 0x30 leaves it intact.
        ramp_phase(1'b1);
        run_cnt(256, cl, cr);
        chk("post_ramp_zero_l", cl, 0, 0);
        chk("post_ramp_zero_r", cr, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
